cpu_mem_bridge: RTL and testbench
=================================

# cpu_mem_bridge

Memory-side neighbour of the CPU core. It accepts the core's registered load/store/instruction-fetch request and holds the core's `enable` low while it runs the access. Each access becomes a sequence of 16-bit little-endian memory beats with byte enables and misaligned support. The result is returned on the core's `data_in`.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 48: CPU data bus width (max access: 6 bytes, 48-bit instruction).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req_valid`  in  1  read or write strobe from the core's output struct.
- `cpu_req_we`  in  1  1 = write, 0 = read.
- `cpu_req_sz`  in  2  request size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 48-bit.
- `cpu_addr`  in  ADDR_W  byte address; any alignment allowed.
- `cpu_wdata`  in  DATA_W  write data, little-endian, byte j at bits [8j+7:8j].
- `cpu_enable`  out  1  drives the core's `enable`.
- `cpu_rdata`  out  DATA_W  drives the core's `data_in`.
- `mem_req`  out  1  beat request.
- `mem_we`  out  1  beat is a write.
- `mem_addr`  out  ADDR_W  halfword address, bit 0 always 0.
- `mem_wdata`  out  16  write lanes: lane 0 = [7:0], lane 1 = [15:8].
- `mem_be`  out  2  lane enables.
- `mem_ack`  in  1  beat done; sampled only while `mem_req` = 1.
- `mem_rdata`  in  16  read data, valid in the ack cycle.

## Operation
Request latch:
- The access is defined by n = bytes (1/2/4/6), off = `cpu_addr[0]`, and beats B = (off + n + 1) >> 1, so 1..4 beats.
- On acceptance, the bridge latches `cpu_req_we`, `cpu_req_sz`, `cpu_addr` and `cpu_wdata` into internal registers. Later input changes are ignored until IDLE.

Beat k (k = 0..B-1):
- Beat address: `mem_addr` = {cpu_addr[ADDR_W-1:1],0} + 2k, modulo 2^ADDR_W, so the address wraps from 0xFFFF_FFFE to 0x0000_0000.
- Lane mapping: lane L carries access byte j = 2k + L − off.
- Lane enable: `mem_be[L]` = 1 iff 0 ≤ j < n. This applies to reads too.
- Writes: lane L of `mem_wdata` = `cpu_wdata` byte j. Disabled lanes drive 0.
- Reads: on ack, enabled lane L is stored into byte j of a read accumulator.

FSM:
- IDLE: `cpu_enable` = !`cpu_req_valid` (combinational); `mem_req` = 0. If `cpu_req_valid` = 1, latch the request, clear the accumulator, set k = 0, and go to BUSY.
- BUSY: `mem_req` = 1, `cpu_enable` = 0. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stable until ack. On ack, if k = B−1 go to DONE, otherwise k++. Without ack, stay indefinitely; there is no timeout.
- DONE: `mem_req` = 0, `cpu_enable` = 1. For a read, `cpu_rdata` = accumulator, with bytes ≥ n equal to 0. The bridge ignores `cpu_req_valid` and goes to IDLE.

Output holding and CPU contract:
- `cpu_rdata` is registered. It is updated only on entry to DONE after a read, and holds otherwise; writes leave it unchanged.
- The core drops or replaces its request on the enabled edge at the end of DONE. A request still high in IDLE is a new access.

Reset:
- State IDLE, k = 0.
- `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` and `cpu_rdata` all 0.
- `cpu_enable` is forced to 0 while `rst` = 1.
- Reset in BUSY abandons the beat: `mem_req` is 0 in the cycle after the reset edge, and a late `mem_ack` is ignored.

## Timing
- Zero-wait memory (ack in the first `mem_req` cycle): `cpu_enable` is low for 1 + B cycles (the IDLE accept cycle plus B beat cycles), then high for exactly 1 DONE cycle.
- W wait cycles per beat add W to the low period per beat.
- `mem_req` rises on the edge after acceptance.
- Between consecutive beats of one access, `mem_req` stays high and fields change on the ack edge.
- `cpu_rdata` is valid from the DONE cycle onward.
- Minimum access period from one IDLE accept to the next is B + 2 cycles.

## Test plan
1. **Aligned 32-bit read at 0x0000_1000, zero-wait, memory halfwords 0xBBAA and 0xDDCC:**
   - 2 beats: addresses 0x1000 then 0x1002, `mem_be` = 11 on both.
   - `cpu_enable` low for 3 cycles.
   - DONE `cpu_rdata` = 0x0000_DDCC_BBAA.
2. **Misaligned 32-bit read at 0x1001:**
   - 3 beats: 0x1000 be=10, 0x1002 be=11, 0x1004 be=01.
   - Bytes assembled little-endian; `cpu_rdata[47:32]` = 0.
3. **Misaligned 48-bit write, addr 0xFFFF_FFFF, `cpu_wdata` 0x665544332211:**
   - 4 beats, with the address wrapping 0xFFFF_FFFE → 0x0000_0000 → 0x0000_0002 → 0x0000_0004.
   - be 10/11/11/01; `mem_wdata` 0x1100, 0x3322, 0x5544, 0x0066.
4. **8-bit read at odd addr with 3 wait cycles:**
   - 1 beat, be=10, `mem_req` held stable for 4 cycles.
   - `cpu_enable` low for 5 cycles; `cpu_rdata` = `mem_rdata[15:8]` zero-extended.
5. **Reset mid-access: `rst` during beat 1 of a 32-bit read:**
   - `mem_req` = 0 the next cycle, all outputs 0, and a late ack is ignored.
   - A following request completes normally.
6. **Back-to-back: `cpu_req_valid` held high through DONE:**
   - No access is started in DONE.
   - A new access starts from the following IDLE cycle.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// Bridges the core's single-cycle load/store/fetch request onto a 16-bit
// little-endian memory port, splitting each access into 1..4 halfword beats.
module cpu_mem_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 48
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   input  logic              cpu_req_we,
   input  logic [1:0]        cpu_req_sz,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_enable,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [1:0]        mem_be,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata
);

   localparam int NBYTES = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         2'd2:    return 3'd4;
         default: return 3'd6;
      endcase
   endfunction

   state_t              state_reg;
   logic                we_reg;
   logic [1:0]          sz_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [1:0]          k_reg;
   logic [DATA_W-1:0]   acc_reg;
   logic [DATA_W-1:0]   acc_next;
   logic [DATA_W-1:0]   cpu_rdata_reg;
   logic                mem_req_reg;
   logic                mem_we_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic [15:0]         mem_wdata_reg;
   logic [1:0]          mem_be_reg;

   logic                is_idle;
   logic [ADDR_W-1:0]   src_addr;
   logic                src_off;
   logic [2:0]          src_n;
   logic [DATA_W-1:0]   src_wdata;
   logic [1:0]          src_k;
   logic [ADDR_W-1:0]   beat_addr_next;
   logic [1:0]          beat_be_next;
   logic [15:0]         beat_wdata_next;
   logic [2:0]          last_span;
   logic [1:0]          last_k;
   logic [2:0]          cur_j [0:1];

   // Next-beat fields come from the live inputs on acceptance and from the
   // latched request when advancing to the following beat.
   assign is_idle   = (state_reg == ST_IDLE);
   assign src_addr  = is_idle ? cpu_addr  : addr_reg;
   assign src_off   = src_addr[0];
   assign src_n     = size_bytes(is_idle ? cpu_req_sz : sz_reg);
   assign src_wdata = is_idle ? cpu_wdata : wdata_reg;
   assign src_k     = is_idle ? 2'd0 : k_reg + 2'd1;

   assign beat_addr_next = {src_addr[ADDR_W-1:1], 1'b0} + ADDR_W'({src_k, 1'b0});

   // Last beat index is B-1 = (off + n - 1) / 2.
   assign last_span = size_bytes(sz_reg) + {2'b00, addr_reg[0]} - 3'd1;
   assign last_k    = 2'(last_span >> 1);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         // Access byte index plus one, so the lane before the access start is 0.
         logic [3:0] j_plus;
         logic [7:0] lane_wdata;

         assign j_plus = {1'b0, src_k, 1'b0} + 4'(gi + 1) - {3'b000, src_off};
         assign beat_be_next[gi] = (j_plus != 4'd0) && (j_plus <= {1'b0, src_n});

         always_comb begin
            lane_wdata = 8'h00;
            for (int b = 0; b < NBYTES; b++) begin
               if (beat_be_next[gi] && (j_plus == 4'(b + 1))) begin
                  lane_wdata = src_wdata[b*8 +: 8];
               end
            end
         end

         assign beat_wdata_next[gi*8 +: 8] = lane_wdata;
         assign cur_j[gi] = {k_reg, 1'b0} + 3'(gi) - {2'b00, addr_reg[0]};
      end

      for (gi = 0; gi < NBYTES; gi++) begin : g_acc
         logic [7:0] acc_byte;

         always_comb begin
            acc_byte = acc_reg[gi*8 +: 8];
            if (mem_be_reg[0] && (cur_j[0] == 3'(gi))) begin
               acc_byte = mem_rdata[7:0];
            end
            if (mem_be_reg[1] && (cur_j[1] == 3'(gi))) begin
               acc_byte = mem_rdata[15:8];
            end
         end

         assign acc_next[gi*8 +: 8] = acc_byte;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         we_reg        <= 1'b0;
         sz_reg        <= 2'd0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         k_reg         <= 2'd0;
         acc_reg       <= '0;
         cpu_rdata_reg <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= 16'h0000;
         mem_be_reg    <= 2'b00;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cpu_req_valid) begin
                  we_reg        <= cpu_req_we;
                  sz_reg        <= cpu_req_sz;
                  addr_reg      <= cpu_addr;
                  wdata_reg     <= cpu_wdata;
                  k_reg         <= 2'd0;
                  acc_reg       <= '0;
                  mem_req_reg   <= 1'b1;
                  mem_we_reg    <= cpu_req_we;
                  mem_addr_reg  <= beat_addr_next;
                  mem_be_reg    <= beat_be_next;
                  mem_wdata_reg <= cpu_req_we ? beat_wdata_next : 16'h0000;
                  state_reg     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  acc_reg <= acc_next;
                  if (k_reg == last_k) begin
                     mem_req_reg   <= 1'b0;
                     mem_be_reg    <= 2'b00;
                     mem_wdata_reg <= 16'h0000;
                     if (!we_reg) begin
                        cpu_rdata_reg <= acc_next;
                     end
                     state_reg <= ST_DONE;
                  end else begin
                     k_reg         <= k_reg + 2'd1;
                     mem_addr_reg  <= beat_addr_next;
                     mem_be_reg    <= beat_be_next;
                     mem_wdata_reg <= we_reg ? beat_wdata_next : 16'h0000;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_enable = !rst && ((is_idle && !cpu_req_valid) || (state_reg == ST_DONE));
   assign cpu_rdata  = cpu_rdata_reg;
   assign mem_req    = mem_req_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign mem_be     = mem_be_reg;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: halfword memory model with programmable
// wait states, beat log, and hand-computed expected beats and read data.
module tb_cpu_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_we = 1'b0;
   logic [1:0]  cpu_req_sz = 2'd0;
   logic [31:0] cpu_addr = 32'h0;
   logic [47:0] cpu_wdata = 48'h0;
   logic        cpu_enable;
   logic [47:0] cpu_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0;

   int n_checks = 0;
   int n_fail = 0;

   cpu_mem_bridge #(.ADDR_W(32), .DATA_W(48)) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_we    (cpu_req_we),
      .cpu_req_sz    (cpu_req_sz),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_enable    (cpu_enable),
      .cpu_rdata     (cpu_rdata),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: answers on the falling edge so the bridge sees ack/rdata
   // at the next rising edge; logs every acknowledged beat.
   logic [15:0] mem_hw [0:4095];
   int          wait_cfg = 0;
   int          wait_cnt = 0;
   bit          force_ack = 1'b0;
   logic [31:0] got_addr_q [$];
   logic [1:0]  got_be_q [$];
   logic [15:0] got_wd_q [$];
   logic        got_we_q [$];
   logic [31:0] exp_addr_q [$];
   logic [1:0]  exp_be_q [$];
   logic [15:0] exp_wd_q [$];
   logic        exp_we_q [$];

   always @(negedge clk) begin
      mem_rdata = mem_hw[mem_addr[12:1]];
      if (mem_req) begin
         if (wait_cnt >= wait_cfg) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            got_addr_q.push_back(mem_addr);
            got_be_q.push_back(mem_be);
            got_wd_q.push_back(mem_wdata);
            got_we_q.push_back(mem_we);
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
         end
      end else begin
         mem_ack  = force_ack;
         wait_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_beat(input logic [31:0] a, input logic [1:0] be,
                              input logic [15:0] wd, input logic we);
      exp_addr_q.push_back(a);
      exp_be_q.push_back(be);
      exp_wd_q.push_back(wd);
      exp_we_q.push_back(we);
   endtask

   task automatic check_beats(input string tag);
      int nb;
      check({tag, " nbeats"}, got_addr_q.size(), exp_addr_q.size());
      nb = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
      for (int i = 0; i < nb; i++) begin
         check($sformatf("%s beat%0d addr", tag, i), got_addr_q[i], exp_addr_q[i]);
         check($sformatf("%s beat%0d be", tag, i), got_be_q[i], exp_be_q[i]);
         check($sformatf("%s beat%0d wdata", tag, i), got_wd_q[i], exp_wd_q[i]);
         check($sformatf("%s beat%0d we", tag, i), got_we_q[i], exp_we_q[i]);
      end
      exp_addr_q.delete();
      exp_be_q.delete();
      exp_wd_q.delete();
      exp_we_q.delete();
   endtask

   // Issues one request and returns in the DONE cycle (negedge + 1).
   task automatic run_access(input string tag, input logic we, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [47:0] wd,
                             input bit keep_valid, output int low, output int reqc,
                             output logic [47:0] rd);
      bit done;
      got_addr_q.delete();
      got_be_q.delete();
      got_wd_q.delete();
      got_we_q.delete();
      @(negedge clk);
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_req_sz    = sz;
      cpu_addr      = addr;
      cpu_wdata     = wd;
      #1;
      low  = cpu_enable ? 0 : 1;
      reqc = 0;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         #1;
         if (mem_req) reqc++;
         if (cpu_enable) done = 1'b1;
         else low++;
      end
      check({tag, " completes"}, done, 1'b1);
      rd = cpu_rdata;
      if (!keep_valid) cpu_req_valid = 1'b0;
      $display("txn %s: we=%0b sz=%0d addr=0x%08h low=%0d req=%0d rdata=0x%012h",
               tag, we, sz, addr, low, reqc, rd);
   endtask

   int          low;
   int          reqc;
   logic [47:0] rd;
   bit          found;

   initial begin
      for (int i = 0; i < 4096; i++) mem_hw[i] = 16'h0000;
      mem_hw[12'h800] = 16'hBBAA;
      mem_hw[12'h801] = 16'hDDCC;
      mem_hw[12'h802] = 16'hFFEE;

      repeat (3) @(negedge clk);
      #1;
      check("reset cpu_enable", cpu_enable, 1'b0);
      check("reset mem_req", mem_req, 1'b0);
      check("reset cpu_rdata", cpu_rdata, 48'h0);
      check("reset mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("idle cpu_enable", cpu_enable, 1'b1);

      // Aligned 32-bit read
      run_access("rd32_aligned", 1'b0, 2'd2, 32'h0000_1000, 48'h0, 1'b0, low, reqc, rd);
      check("rd32_aligned low", low, 3);
      check("rd32_aligned rdata", rd, 48'h0000_DDCC_BBAA);
      expect_beat(32'h1000, 2'b11, 16'h0, 1'b0);
      expect_beat(32'h1002, 2'b11, 16'h0, 1'b0);
      check_beats("rd32_aligned");

      // Misaligned 32-bit read
      run_access("rd32_odd", 1'b0, 2'd2, 32'h0000_1001, 48'h0, 1'b0, low, reqc, rd);
      check("rd32_odd low", low, 4);
      check("rd32_odd rdata", rd, 48'h0000_EEDD_CCBB);
      expect_beat(32'h1000, 2'b10, 16'h0, 1'b0);
      expect_beat(32'h1002, 2'b11, 16'h0, 1'b0);
      expect_beat(32'h1004, 2'b01, 16'h0, 1'b0);
      check_beats("rd32_odd");

      // Misaligned 48-bit write wrapping through address 0
      run_access("wr48_wrap", 1'b1, 2'd3, 32'hFFFF_FFFF, 48'h6655_4433_2211, 1'b0, low, reqc, rd);
      check("wr48_wrap low", low, 5);
      check("wr48_wrap rdata held", rd, 48'h0000_EEDD_CCBB);
      expect_beat(32'hFFFF_FFFE, 2'b10, 16'h1100, 1'b1);
      expect_beat(32'h0000_0000, 2'b11, 16'h3322, 1'b1);
      expect_beat(32'h0000_0002, 2'b11, 16'h5544, 1'b1);
      expect_beat(32'h0000_0004, 2'b01, 16'h0066, 1'b1);
      check_beats("wr48_wrap");

      // 8-bit read at odd address with 3 wait cycles
      wait_cfg = 3;
      run_access("rd8_wait3", 1'b0, 2'd0, 32'h0000_1003, 48'h0, 1'b0, low, reqc, rd);
      wait_cfg = 0;
      check("rd8_wait3 low", low, 5);
      check("rd8_wait3 req cycles", reqc, 4);
      check("rd8_wait3 rdata", rd, 48'h0000_0000_00DD);
      expect_beat(32'h1002, 2'b10, 16'h0, 1'b0);
      check_beats("rd8_wait3");

      // Misaligned 16-bit read straddling two halfwords
      run_access("rd16_odd", 1'b0, 2'd1, 32'h0000_1003, 48'h0, 1'b0, low, reqc, rd);
      check("rd16_odd low", low, 3);
      check("rd16_odd rdata", rd, 48'h0000_0000_EEDD);
      expect_beat(32'h1002, 2'b10, 16'h0, 1'b0);
      expect_beat(32'h1004, 2'b01, 16'h0, 1'b0);
      check_beats("rd16_odd");

      // Aligned 16-bit write; upper write bytes must not leak out
      run_access("wr16_al", 1'b1, 2'd1, 32'h0000_2000, 48'h1234_5678_ABCD, 1'b0, low, reqc, rd);
      check("wr16_al low", low, 2);
      expect_beat(32'h2000, 2'b11, 16'hABCD, 1'b1);
      check_beats("wr16_al");

      // Reset during beat 1 of a 32-bit read
      wait_cfg = 2;
      @(negedge clk);
      cpu_req_valid = 1'b1;
      cpu_req_we    = 1'b0;
      cpu_req_sz    = 2'd2;
      cpu_addr      = 32'h0000_1000;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         #1;
         if (mem_req && mem_addr == 32'h0000_1002) found = 1'b1;
      end
      check("rst reached beat1", found, 1'b1);
      rst = 1'b1;
      cpu_req_valid = 1'b0;
      @(negedge clk);
      #1;
      check("rst mem_req", mem_req, 1'b0);
      check("rst mem_be", mem_be, 2'b00);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst mem_wdata", mem_wdata, 16'h0);
      check("rst mem_we", mem_we, 1'b0);
      check("rst cpu_rdata", cpu_rdata, 48'h0);
      check("rst cpu_enable", cpu_enable, 1'b0);
      rst = 1'b0;
      force_ack = 1'b1;
      @(negedge clk);
      #1;
      force_ack = 1'b0;
      @(negedge clk);
      #1;
      check("late ack mem_req", mem_req, 1'b0);
      check("late ack cpu_enable", cpu_enable, 1'b1);
      $display("txn rst_mid_beat: reset applied in beat 1, late ack presented");
      wait_cfg = 0;
      run_access("rd32_after_rst", 1'b0, 2'd2, 32'h0000_1000, 48'h0, 1'b0, low, reqc, rd);
      check("rd32_after_rst low", low, 3);
      check("rd32_after_rst rdata", rd, 48'h0000_DDCC_BBAA);

      // Back-to-back: request held through DONE, then replaced
      run_access("b2b_first", 1'b0, 2'd2, 32'h0000_1000, 48'h0, 1'b1, low, reqc, rd);
      check("b2b_first rdata", rd, 48'h0000_DDCC_BBAA);
      cpu_req_sz = 2'd1;
      cpu_addr   = 32'h0000_1004;
      @(negedge clk);
      #1;
      check("b2b idle mem_req", mem_req, 1'b0);
      check("b2b idle cpu_enable", cpu_enable, 1'b0);
      @(negedge clk);
      #1;
      check("b2b second mem_req", mem_req, 1'b1);
      check("b2b second mem_addr", mem_addr, 32'h0000_1004);
      check("b2b second mem_be", mem_be, 2'b11);
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         if (cpu_enable) found = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      check("b2b second completes", found, 1'b1);
      check("b2b second rdata", cpu_rdata, 48'h0000_0000_FFEE);
      cpu_req_valid = 1'b0;
      $display("txn b2b_second: sz=1 addr=0x00001004 rdata=0x%012h", cpu_rdata);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
